// File: rtl/imem_boot_loader_if.sv
// Bus bundle between the boot loader and the outside world.
// Carries two groups of signals:
//   - program source read port: src_rd / src_addr out, src_data / src_valid back
//   - instruction memory write port: imem_we / imem_addr / imem_wdata out
// The master modport is the loader side. The slave modport is the
// source + instruction memory side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();

  logic              src_rd;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output src_rd, src_addr, imem_we, imem_addr, imem_wdata,
    input  src_data, src_valid
  );

  modport slave (
    input  src_rd, src_addr, imem_we, imem_addr, imem_wdata,
    output src_data, src_valid
  );

endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time program loader for the risc core.
// After reset it copies PROG_LEN words from the program source into the
// instruction memory. It keeps the core in reset until the copy is
// finished. Once a copy completes, a reload request starts a fresh copy.
// If the source stalls longer than TIMEOUT cycles on one word, the loader
// parks in a sticky error state.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   reload        request a fresh copy; only honoured while the core runs
//   bus           master side of imem_boot_loader_if (source read + imem write)
//   cpu_rst       reset to the core, 1 = held in reset
//   done          copy complete and core running
//   error         source timeout, sticky until rst
//   words_loaded  words written so far in the current copy (reaches PROG_LEN)
module imem_boot_loader #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int PROG_LEN = 256,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  imem_boot_loader_if.master    bus,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W:0]       words_loaded
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  LAST_CNT  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_RUN, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              src_rd_q, src_rd_d;
  logic              imem_we_q, imem_we_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Next-state logic. Every output is registered and decoded from the
  // next state. That way each output lines up with the state it belongs to
  // in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data arriving on the threshold cycle still wins over the timeout.
        if (bus.src_valid) begin
          wdata_d = bus.src_data;
          state_d = S_WRITE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_d == TMR_LIMIT) begin
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + (ADDR_W+1)'(1);
        state_d = (cnt_d == LAST_CNT) ? S_RUN : S_REQ;
      end
      S_RUN: begin
        if (reload) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // On entry to WRITE the count has not yet advanced, so cnt_d is the
    // address of the word being written. On entry to REQ it is the next word.
    src_rd_d    = (state_d == S_REQ);
    src_addr_d  = (state_d == S_REQ) ? cnt_d[ADDR_W-1:0] : src_addr_q;
    imem_we_d   = (state_d == S_WRITE);
    imem_addr_d = (state_d == S_WRITE) ? cnt_d[ADDR_W-1:0] : imem_addr_q;
    cpu_rst_d   = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERR);
  end

  // State and output registers. A reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      wdata_q     <= '0;
      src_addr_q  <= '0;
      imem_addr_q <= '0;
      src_rd_q    <= 1'b0;
      imem_we_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      wdata_q     <= wdata_d;
      src_addr_q  <= src_addr_d;
      imem_addr_q <= imem_addr_d;
      src_rd_q    <= src_rd_d;
      imem_we_q   <= imem_we_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.src_rd     = src_rd_q;
  assign bus.src_addr   = src_addr_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader.
// There are two instances:
//   - a 4-word loader, driven by a randomized program source with a
//     configurable latency, stray valid pulses and a non-responding word
//   - a full 1024-word loader at L=1, used to check that the last address
//     is written and the counter does not wrap
// A source process pushes the expected write into a queue every time it
// delivers a word. A separate monitor pops the queue and compares on each
// imem_we.
module tb_imem_boot_loader;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int PL     = 4;
  localparam int TO     = 15;
  localparam int BIG_PL = 1024;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, reload, cpu_rst, done, error;
  logic [AW:0]   words_loaded;
  logic          rst2, reload2, cpu_rst2, done2, error2;
  logic [AW:0]   words_loaded2;

  imem_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  imem_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  imem_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .PROG_LEN(PL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .reload(reload), .bus(bus),
    .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  imem_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .PROG_LEN(BIG_PL), .TIMEOUT(TO)) dut_big (
    .clk(clk), .rst(rst2), .reload(reload2), .bus(bus2),
    .cpu_rst(cpu_rst2), .done(done2), .error(error2), .words_loaded(words_loaded2)
  );

  int total = 0;
  int bad   = 0;

  // Source model configuration
  logic [DW-1:0] src_mem [PL];
  int  lat_mode  = 0;
  bit  stray_en  = 0;
  bit  long_en   = 0;
  int  long_addr = 0;
  int  long_lat  = 1;
  bit  hang_en   = 0;
  int  hang_addr = 0;
  int  lat_tab [4] = '{1, 3, 5, 2};
  int  lat_sum   = 0;
  wr_t exp_q [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pickLat(input int a);
    if (long_en && a == long_addr) return long_lat;
    case (lat_mode)
      0:       return 1;
      1:       return lat_tab[a % 4];
      default: return int'($urandom_range(1, 5));
    endcase
  endfunction

  task automatic applyStimulus(input int mode, input bit stray, input bit l_en, input int l_addr,
                               input int l_lat, input bit h_en, input int h_addr);
    @(negedge clk);
    lat_mode  = mode;
    stray_en  = stray;
    long_en   = l_en;
    long_addr = l_addr;
    long_lat  = l_lat;
    hang_en   = h_en;
    hang_addr = h_addr;
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " src_rd"}, bus.src_rd, 0);
    checkOutput({name, " src_addr"}, bus.src_addr, 0);
    checkOutput({name, " imem_we"}, bus.imem_we, 0);
    checkOutput({name, " imem_addr"}, bus.imem_addr, 0);
    checkOutput({name, " imem_wdata"}, bus.imem_wdata, 0);
    checkOutput({name, " cpu_rst"}, cpu_rst, 1);
    checkOutput({name, " done"}, done, 0);
    checkOutput({name, " error"}, error, 0);
    checkOutput({name, " words_loaded"}, words_loaded, 0);
  endtask

  task automatic applyReset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkReset(name);
  endtask

  // Releases rst (or pulses reload) and counts the edges until the core
  // is released. The expected count is 1 + sum(2 + L) over the words.
  task automatic runLoad(input string name, input bit use_reload);
    int n;
    @(negedge clk);
    lat_sum = 0;
    if (use_reload) reload = 1'b1;
    else rst = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && use_reload) begin
        reload = 1'b0;
        checkOutput({name, " reload cpu_rst"}, cpu_rst, 1);
        checkOutput({name, " reload done"}, done, 0);
        checkOutput({name, " reload words_loaded"}, words_loaded, 0);
      end
      if (cpu_rst === 1'b0) break;
    end
    checkOutput({name, " load cycles"}, n, 1 + 2 * PL + lat_sum);
    checkOutput({name, " done"}, done, 1);
    checkOutput({name, " words_loaded"}, words_loaded, PL);
    checkOutput({name, " error"}, error, 0);
    checkOutput({name, " writes pending"}, exp_q.size(), 0);
  endtask

  task automatic waitRead(input string name, input int target);
    bit found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.src_rd === 1'b1 && bus.src_addr == AW'(target)) begin
        found = 1;
        break;
      end
    end
    checkOutput({name, " read seen"}, found, 1);
  endtask

  // Program source with variable latency. It also keeps the reference
  // read-address sequence and queues each expected write.
  initial begin
    bit  pend;
    bit  hang_now;
    int  cd;
    int  plat;
    int  paddr;
    int  exp_rd_addr;
    pend          = 0;
    hang_now      = 0;
    cd            = 0;
    plat          = 0;
    paddr         = 0;
    exp_rd_addr   = 0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.src_valid = 1'b0;
      bus.src_data  = '0;
      if (rst) begin
        pend        = 0;
        exp_rd_addr = 0;
        exp_q.delete();
      end else begin
        if (pend && !hang_now) begin
          cd--;
          if (cd == 0) begin
            bus.src_valid = 1'b1;
            bus.src_data  = src_mem[paddr];
            exp_q.push_back('{addr: AW'(paddr), data: src_mem[paddr]});
            lat_sum += plat;
            pend = 0;
          end
        end else if (!pend && stray_en && $urandom_range(0, 2) == 0) begin
          bus.src_valid = 1'b1;
          bus.src_data  = $urandom;
        end
        if (bus.src_rd === 1'b1) begin
          checkOutput("read addr", bus.src_addr, exp_rd_addr);
          pend        = 1;
          paddr       = exp_rd_addr;
          plat        = pickLat(paddr);
          cd          = plat;
          hang_now    = hang_en && (paddr == hang_addr);
          exp_rd_addr = (exp_rd_addr + 1) % PL;
        end
      end
    end
  end

  // Write monitor
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, expected no write",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write addr", bus.imem_addr, e.addr);
          checkOutput("write data", bus.imem_wdata, e.data);
        end
      end
    end
  end

  // Fixed L=1 source for the full-size instance
  initial begin
    bit            pend2;
    logic [AW-1:0] addr2;
    pend2          = 0;
    addr2          = '0;
    bus2.src_valid = 1'b0;
    bus2.src_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst2) begin
        pend2          = 0;
        bus2.src_valid = 1'b0;
      end else begin
        bus2.src_valid = pend2;
        bus2.src_data  = 32'hA000_0000 + DW'(addr2);
        pend2          = bus2.src_rd;
        addr2          = bus2.src_addr;
      end
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int wcnt;
    int rd_cnt;
    rst     = 1'b1;
    reload  = 1'b0;
    rst2    = 1'b1;
    reload2 = 1'b0;
    for (int a = 0; a < PL; a++) src_mem[a] = 32'hA000_0000 + DW'(a);

    // Reset values, then a basic copy at L=1. This is 13 cycles to release.
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    runLoad("basic", 0);

    // Latencies 1,3,5,2 with stray valid pulses and random data
    for (int a = 0; a < PL; a++) src_mem[a] = $urandom;
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    applyReset("reset2");
    runLoad("pattern", 0);
    repeat (5) @(posedge clk);

    // Reload from RUN. Word 1 answers exactly on the timeout threshold.
    applyStimulus(2, 1, 1, 1, TO, 0, 0);
    runLoad("reload_thr", 1);
    for (int a = 0; a < PL; a++) src_mem[a] = $urandom;
    applyStimulus(2, 0, 0, 0, 1, 0, 0);
    runLoad("reload_rand", 1);

    // Word 2 never answers, so the loader must time out
    applyStimulus(0, 0, 0, 0, 1, 1, 2);
    applyReset("reset_to");
    @(negedge clk);
    rst = 1'b0;
    waitRead("timeout", 2);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (error === 1'b1) break;
    end
    checkOutput("timeout wait cycles", n - 1, TO);
    checkOutput("timeout cpu_rst", cpu_rst, 1);
    checkOutput("timeout done", done, 0);
    checkOutput("timeout words_loaded", words_loaded, 2);
    rd_cnt = 0;
    @(negedge clk);
    reload = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) reload = 1'b0;
      if (bus.src_rd === 1'b1) rd_cnt++;
    end
    checkOutput("err reads after reload", rd_cnt, 0);
    checkOutput("err sticky", error, 1);
    checkOutput("err words_loaded", words_loaded, 2);
    applyStimulus(2, 1, 0, 0, 1, 0, 0);
    applyReset("reset_err");
    runLoad("after_err", 0);

    // Reset during the wait for word 3
    applyStimulus(0, 0, 1, 3, 8, 0, 0);
    applyReset("reset3");
    @(negedge clk);
    rst = 1'b0;
    waitRead("mid", 3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkReset("mid_wait_reset");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    runLoad("after_mid", 0);

    // Full address-space copy on the second instance
    @(negedge clk);
    rst2 = 1'b0;
    n    = 0;
    wcnt = 0;
    while (n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus2.imem_we === 1'b1) begin
        checkOutput("big write addr", bus2.imem_addr, wcnt);
        checkOutput("big write data", bus2.imem_wdata, 32'hA000_0000 + wcnt);
        wcnt++;
      end
      if (cpu_rst2 === 1'b0) break;
    end
    checkOutput("big load cycles", n, 1 + 3 * BIG_PL);
    checkOutput("big write count", wcnt, BIG_PL);
    checkOutput("big last addr", bus2.imem_addr, BIG_PL - 1);
    checkOutput("big words_loaded", words_loaded2, BIG_PL);
    checkOutput("big done", done2, 1);
    checkOutput("big error", error2, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader sitting directly upstream of the `risc` core. After reset it copies `PROG_LEN` instruction words from a program source (ROM/flash model with variable read latency) into the core's instruction memory write port, holding the core in reset until the copy completes. On completion it releases the core by driving `cpu_rst` low. It also supports a re-load on request and flags a source timeout.

## Interface
Parameters:
- `ADDR_W`, 10, instruction-memory/source word-address width
- `DATA_W`, 32, instruction word width
- `PROG_LEN`, 256, words to copy; legal range 1..2^ADDR_W
- `TIMEOUT`, 15, max cycles waiting for `src_valid` per word; legal range ≥1

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `reload`  in  1  request a fresh copy; honoured only in RUN
- `src_rd`  out  1  one-cycle read strobe to program source
- `src_addr`  out  ADDR_W  source word address
- `src_data`  in  DATA_W  source read data, valid when `src_valid`
- `src_valid`  in  1  source read-data qualifier
- `imem_we`  out  1  instruction-memory write enable
- `imem_addr`  out  ADDR_W  instruction-memory write address
- `imem_wdata`  out  DATA_W  instruction-memory write data
- `cpu_rst`  out  1  reset to `risc`; 1 = core held in reset
- `done`  out  1  copy complete, core running
- `error`  out  1  source timeout; sticky until `rst`
- `words_loaded`  out  ADDR_W+1  count of words written in current copy

## Operation
- States: IDLE, REQ, WAIT, WRITE, RUN, ERR.
- IDLE: entered on `rst`; next cycle → REQ. Counter `cnt` = 0.
- REQ: `src_rd`=1, `src_addr`=`cnt`; wait timer cleared; → WAIT.
- WAIT: `src_rd`=0. On `src_valid`=1 capture `src_data` into data register, → WRITE. Otherwise timer increments; when timer reaches `TIMEOUT` with no `src_valid`, → ERR.
- WRITE: `imem_we`=1, `imem_addr`=`cnt`, `imem_wdata`=captured word; `cnt` increments. If new `cnt` == `PROG_LEN` → RUN, else → REQ.
- RUN: `cpu_rst`=0, `done`=1. `reload`=1 → REQ with `cnt` cleared, `words_loaded` cleared; `cpu_rst` returns to 1 and `done` to 0 the same edge.
- ERR: `error`=1, `cpu_rst`=1, `done`=0, no further reads/writes; exits only via `rst`.
- `words_loaded` = `cnt`; reaches `PROG_LEN` exactly (hence ADDR_W+1 bits, no wrap when `PROG_LEN`=2^ADDR_W).
- `src_valid` outside WAIT is ignored. `src_valid` in the same cycle as the timeout threshold counts as valid (data wins).
- `reload` outside RUN is ignored.
- `cpu_rst`=1 in every state except RUN.

## Timing
- Reset values (cycle after `rst` sampled high): `src_rd`=0, `src_addr`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `error`=0, `words_loaded`=0, state IDLE.
- `rst` mid-copy or in RUN/ERR: in-flight read abandoned, no write issued on the following cycle, copy restarts from word 0.
- Per word: REQ(1) + WAIT(L, L≥1 = cycles from `src_rd` to `src_valid`) + WRITE(1). Source with L=1: 3 cycles/word.
- Total from `rst` release to `cpu_rst` low = 1 (IDLE) + PROG_LEN·(2+L) cycles; `done` and `cpu_rst` change on the same edge.
- Outputs are registered; `imem_we` is high for exactly one cycle per word, never in RUN/ERR/IDLE.
- Timeout: ERR entered on the edge after `TIMEOUT` consecutive WAIT cycles without `src_valid`.

## Test plan
- PROG_LEN=4, source L=1 returning 0xA0000000+addr → four writes addr 0..3, data 0xA0000000..0xA0000003; `cpu_rst` falls 13 cycles after `rst` release; `done`=1, `words_loaded`=4.
- Source L varying 1,3,5,2 → same write sequence, no extra/missing `imem_we` pulses; stray `src_valid` pulse in REQ/WRITE causes no write.
- Source never asserts `src_valid` for word 2, TIMEOUT=15 → ERR 15 WAIT cycles after word-2 `src_rd`; `error`=1, `cpu_rst`=1, `words_loaded`=2; `reload` ignored; `rst` restarts from word 0.
- In RUN pulse `reload` → `cpu_rst`=1 and `done`=0 next edge, full 4-word copy repeats from addr 0, then RUN again.
- Assert `rst` during WAIT of word 3 → next cycle all outputs at reset values, no write to addr 3, load restarts at addr 0.
- PROG_LEN=2^ADDR_W (1024), L=1 → last write at addr 1023, `words_loaded`=1024, no wrap, `done`=1.
